// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised 16x-oversampled UART receiver with majority vote and error flags
module uart_rx_param #(
  parameter int DATA_W      = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_tick_16x,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              break_det,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     rx_s;
  logic [3:0]               tick_cnt;
  logic [3:0]               bit_cnt;
  logic [1:0]               smp;
  logic [DATA_W-1:0]        shift_q;
  logic                     par_q;

  logic vote, tick_mid, tick_end, last_data, last_stop;
  logic frame_done, ferr_d, brk_d, perr_d, par_calc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  // tick_cnt holds the index of the last tick seen in the current bit
  assign tick_mid  = baud_tick_16x && (tick_cnt == 4'd8);
  assign tick_end  = baud_tick_16x && (tick_cnt == 4'd15);
  assign vote      = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign last_data = (bit_cnt == 4'(DATA_W - 1));
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
  assign par_calc  = (^shift_q) ^ par_q;
  assign perr_d    = (PARITY == 1) ? par_calc : (PARITY == 2) ? ~par_calc : 1'b0;
  assign brk_d     = ferr_d && (bit_cnt == 4'd0) && (shift_q == '0) && ((PARITY == 0) || !par_q);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      IDLE:  if (baud_tick_16x && !rx_s) state_d = START;
      START: begin
        if (tick_mid && vote)  state_d = IDLE;
        else if (tick_end)     state_d = DATA;
      end
      DATA:  if (tick_end && last_data) state_d = (PARITY != 0) ? PAR : STOP;
      PAR:   if (tick_end) state_d = STOP;
      STOP: begin
        if (tick_mid) begin
          if (!vote) begin
            frame_done = 1'b1;
            ferr_d     = 1'b1;
          end else if (last_stop) begin
            frame_done = 1'b1;
          end
        end
        if (frame_done) state_d = brk_d ? BRK : IDLE;
      end
      BRK:   if (baud_tick_16x && rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      smp        <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      rx_valid <= frame_done;
      if (state_q == IDLE || state_q == BRK) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (baud_tick_16x) begin
        tick_cnt <= tick_cnt + 4'd1;
        if (tick_cnt == 4'd6) smp[0] <= rx_s;
        if (tick_cnt == 4'd7) smp[1] <= rx_s;
        if (tick_mid && state_q == DATA) shift_q <= {vote, shift_q[DATA_W-1:1]};
        if (tick_mid && state_q == PAR)  par_q   <= vote;
        if (tick_end && state_q == DATA) bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
        if (tick_end && state_q == STOP) bit_cnt <= bit_cnt + 4'd1;
      end
      if (frame_done) begin
        rx_data    <= shift_q;
        parity_err <= perr_d;
        frame_err  <= ferr_d;
        break_det  <= brk_d;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param across four configurations
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [1:0] div = 2'd0;
  logic       rxl [4];
  logic       vld [4];
  logic       perr [4];
  logic       ferr [4];
  logic       brk [4];
  logic       bsy [4];
  logic [7:0] d_a, d_b, d_c;
  logic [4:0] d_d;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_num = 0;
  int t_start  = 0;
  int vcnt  [4];
  int vtick [4];

  always #5 clk = ~clk;

  // tick changes on the falling edge so it is stable at every rising edge
  always @(negedge clk) begin
    div       <= div + 2'd1;
    baud_tick <= (div == 2'd3);
  end

  always @(posedge clk) if (baud_tick) tick_num <= tick_num + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (vld[k]) begin
        vcnt[k]  = vcnt[k] + 1;
        vtick[k] = tick_num;
      end
    end
  end

  uart_rx_param #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .baud_tick_16x(baud_tick), .rx(rxl[0]), .rx_data(d_a),
    .rx_valid(vld[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .break_det(brk[0]), .busy(bsy[0]));
  uart_rx_param #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .baud_tick_16x(baud_tick), .rx(rxl[1]), .rx_data(d_b),
    .rx_valid(vld[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .break_det(brk[1]), .busy(bsy[1]));
  uart_rx_param #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .baud_tick_16x(baud_tick), .rx(rxl[2]), .rx_data(d_c),
    .rx_valid(vld[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .break_det(brk[2]), .busy(bsy[2]));
  uart_rx_param #(.DATA_W(5), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(3)) dut_d (
    .clk(clk), .rst_n(rst_n), .baud_tick_16x(baud_tick), .rx(rxl[3]), .rx_data(d_d),
    .rx_valid(vld[3]), .parity_err(perr[3]), .frame_err(ferr[3]), .break_det(brk[3]), .busy(bsy[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (baud_tick !== 1'b1);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
    #1;
  endtask

  // bits[0] is the start bit; glitch inverts the line on tick 8 only of that bit
  task automatic send_frame(input int d, input logic [15:0] bits, input int n, input int glitch);
    wait_ticks(1);
    t_start = tick_num + 1;
    for (int i = 0; i < n; i++) begin
      rxl[d] = bits[i];
      if (i == glitch) begin
        wait_ticks(8);
        rxl[d] = ~bits[i];
        wait_ticks(1);
        rxl[d] = bits[i];
        wait_ticks(7);
      end else begin
        wait_ticks(16);
      end
    end
    rxl[d] = 1'b1;
    wait_ticks(8);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      rxl[k]  = 1'b1;
      vcnt[k] = 0;
      vtick[k] = 0;
    end
    repeat (4) @(posedge clk);
    #1;
    check("rst_data_a", {24'd0, d_a}, 32'd0);
    check("rst_flags_a", {28'd0, vld[0], perr[0], ferr[0], brk[0]}, 32'd0);
    check("rst_busy_all", {28'd0, bsy[0], bsy[1], bsy[2], bsy[3]}, 32'd0);
    rst_n = 1'b1;
    wait_ticks(4);

    send_frame(0, 16'({1'b1, 8'hAB, 1'b0}), 10, -1);
    check("a_ab_cnt", vcnt[0], 1);
    check("a_ab_data", {24'd0, d_a}, 32'hAB);
    check("a_ab_flags", {29'd0, perr[0], ferr[0], brk[0]}, 32'd0);
    check("a_ab_latency", vtick[0], t_start + 153);
    check("a_ab_busy", {31'd0, bsy[0]}, 32'd0);

    send_frame(0, 16'({1'b1, 8'hAB, 1'b0}), 10, 3);
    check("a_vote_cnt", vcnt[0], 2);
    check("a_vote_data", {24'd0, d_a}, 32'hAB);

    send_frame(1, 16'({1'b1, 1'b0, 8'h5A, 1'b0}), 11, -1);
    check("b_even_ok_cnt", vcnt[1], 1);
    check("b_even_ok_perr", {31'd0, perr[1]}, 32'd0);
    send_frame(1, 16'({1'b1, 1'b1, 8'h5A, 1'b0}), 11, -1);
    check("b_even_bad_perr", {31'd0, perr[1]}, 32'd1);
    check("b_even_bad_data", {24'd0, d_b}, 32'h5A);
    check("b_even_bad_ferr", {31'd0, ferr[1]}, 32'd0);
    send_frame(2, 16'({1'b1, 1'b1, 8'h5A, 1'b0}), 11, -1);
    check("c_odd_ok_cnt", vcnt[2], 1);
    check("c_odd_ok_perr", {31'd0, perr[2]}, 32'd0);
    check("c_odd_ok_data", {24'd0, d_c}, 32'h5A);

    // false start: low for ticks 0..3 of the start bit
    wait_ticks(1);
    rxl[0] = 1'b0;
    wait_ticks(4);
    rxl[0] = 1'b1;
    wait_ticks(5);
    check("fs_busy_t8", {31'd0, bsy[0]}, 32'd1);
    wait_ticks(1);
    check("fs_busy_t9", {31'd0, bsy[0]}, 32'd0);
    wait_ticks(8);
    check("fs_no_valid", vcnt[0], 2);
    send_frame(0, 16'({1'b1, 8'h3C, 1'b0}), 10, -1);
    check("fs_next_data", {24'd0, d_a}, 32'h3C);
    check("fs_next_cnt", vcnt[0], 3);

    send_frame(0, 16'({1'b0, 8'h3C, 1'b0}), 10, -1);
    wait_ticks(16);
    check("ferr_cnt", vcnt[0], 4);
    check("ferr_data", {24'd0, d_a}, 32'h3C);
    check("ferr_flag", {31'd0, ferr[0]}, 32'd1);
    check("ferr_brk", {31'd0, brk[0]}, 32'd0);
    send_frame(0, 16'({1'b1, 8'h55, 1'b0}), 10, -1);
    check("ferr_clear_data", {24'd0, d_a}, 32'h55);
    check("ferr_clear_flags", {29'd0, perr[0], ferr[0], brk[0]}, 32'd0);

    // line held low for three frame times
    wait_ticks(1);
    rxl[0] = 1'b0;
    wait_ticks(480);
    check("brk_cnt", vcnt[0], 6);
    check("brk_data", {24'd0, d_a}, 32'h00);
    check("brk_flags", {30'd0, ferr[0], brk[0]}, 32'd3);
    check("brk_busy_low", {31'd0, bsy[0]}, 32'd1);
    rxl[0] = 1'b1;
    wait_ticks(4);
    check("brk_busy_high", {31'd0, bsy[0]}, 32'd0);
    check("brk_cnt_after", vcnt[0], 6);
    send_frame(0, 16'({1'b1, 8'h55, 1'b0}), 10, -1);
    check("brk_next_data", {24'd0, d_a}, 32'h55);
    check("brk_next_flags", {29'd0, perr[0], ferr[0], brk[0]}, 32'd0);

    send_frame(3, 16'({2'b11, 5'h15, 1'b0}), 8, -1);
    check("d_15_cnt", vcnt[3], 1);
    check("d_15_data", {27'd0, d_d}, 32'h15);
    check("d_15_latency", vtick[3], t_start + 121);
    check("d_15_flags", {29'd0, perr[3], ferr[3], brk[3]}, 32'd0);

    // reset during data bit 3 of 0x0A
    wait_ticks(1);
    rxl[3] = 1'b0;
    wait_ticks(16);
    rxl[3] = 1'b0;
    wait_ticks(16);
    rxl[3] = 1'b1;
    wait_ticks(16);
    rxl[3] = 1'b0;
    wait_ticks(16);
    rxl[3] = 1'b1;
    wait_ticks(8);
    rst_n = 1'b0;
    #1;
    check("rst_mid_data", {27'd0, d_d}, 32'd0);
    check("rst_mid_outs", {27'd0, vld[3], perr[3], ferr[3], brk[3], bsy[3]}, 32'd0);
    rxl[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ticks(40);
    check("rst_mid_no_valid", vcnt[3], 1);
    send_frame(3, 16'({2'b11, 5'h0A, 1'b0}), 8, -1);
    check("rst_after_cnt", vcnt[3], 2);
    check("rst_after_data", {27'd0, d_d}, 32'h0A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, successor to the fixed 8N1 `uart_rx`. It recovers frames from the asynchronous `rx` line using the shared 16x oversampling tick from `baud_gen_16x`. Data width, parity mode and stop-bit count are configurable. It adds 3-sample majority voting, false-start rejection, parity/framing error flags and line-break detection, and presents each frame to the host logic with a one-cycle valid strobe.

## Interface
- `DATA_W`, 8: data bits per frame, legal 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `SYNC_STAGES`, 2: synchroniser flops on `rx`, legal ≥2.
- `clk` input 1: single clock; all logic on posedge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `baud_tick_16x` input 1: one-`clk`-wide pulse, 16 per bit period.
- `rx` input 1: serial line, idle high, asynchronous to `clk`.
- `rx_data` output `DATA_W`: received word, LSB first on the line.
- `rx_valid` output 1: one-cycle strobe; `rx_data` and the flags are valid.
- `parity_err` output 1: parity mismatch for the frame (always 0 when `PARITY`=0).
- `frame_err` output 1: a stop bit was sampled low.
- `break_det` output 1: break condition (all data bits 0, parity bit 0 if present, stop bit 0).
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through `SYNC_STAGES` flops (reset value 1), giving `rx_s`. All decisions use `rx_s`.
- FSM states: IDLE, START, DATA, PAR, STOP, BRK.
- A 4-bit `tick_cnt` advances only on `baud_tick_16x`. A bit counter tracks DATA and STOP progress.
- IDLE: on a tick with `rx_s`=0, go to START with `tick_cnt`=0. That tick is tick 0 of the start bit.
- Within each bit, `rx_s` is sampled on ticks 7, 8 and 9. The bit value is the majority of the 3 samples, decided on tick 9. Moving to the next bit happens on tick 15, with `tick_cnt` wrapping to 0.
- START: if the majority at tick 9 is 1, this is a false start; return to IDLE on that tick and produce no output.
- DATA: shift in `DATA_W` bits, LSB first.
- PAR: entered only when `PARITY`≠0.
  - Even: error if XOR(data, parity bit) = 1.
  - Odd: error if XOR(data, parity bit) = 0.
- STOP: each stop bit is decided at its tick 9.
  - A 0 ends the frame immediately with `frame_err`=1.
  - A 1 on the last stop bit ends the frame with `frame_err`=0.
  - With `STOP_BITS`=2, the second stop bit is checked only if the first was 1.
- Frame end:
  - On the decision clk edge, register `rx_data`, `parity_err`, `frame_err` and `break_det`, and set `rx_valid`=1 for exactly one clk.
  - Next state is IDLE, or BRK if `break_det`. The receiver re-arms from mid-stop-bit.
- BRK: stay until a tick with `rx_s`=1, then go to IDLE. No frames are produced while the line is held low.
- `rx_data` and the flags hold their values until the next frame end. `rx_data` is updated even on error.

## Timing
- Reset (async assert): FSM=IDLE, counters=0, sync flops=1, `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `break_det`=0, `busy`=0.
- Reset mid-frame aborts the frame with no `rx_valid`.
- Input latency: `SYNC_STAGES` clk cycles from `rx` to `rx_s`.
- Latency from the start tick to `rx_valid` is 16·(1 + `DATA_W` + P + k − 1) + 9 ticks + 1 clk, where:
  - P = 1 if `PARITY`≠0, else 0;
  - k = index of the stop bit that ends the frame (1 or 2).
- `busy` rises on the clk after the start tick and falls with the IDLE return (same edge as `rx_valid` rises).
- Ticks that arrive while in IDLE with `rx_s`=1 are ignored.
- No backpressure. A host that misses the `rx_valid` strobe loses the frame.

## Test plan
- 8N1 (defaults), send 0xAB -> one `rx_valid` pulse, `rx_data`=0xAB, all flags 0. Repeat with `rx` forced high for ticks 8 only of data bit 2 -> still 0xAB (majority vote).
- `PARITY`=1, send 0x5A with parity bit 0 -> `parity_err`=0. Send 0x5A with parity bit 1 -> `parity_err`=1, `rx_data`=0x5A. `PARITY`=2 with parity bit 1 -> `parity_err`=0.
- Line low for 4 ticks then high -> no `rx_valid`. `busy` returns to 0 at tick 9. A following 0x3C frame is received cleanly.
- Send 0x3C with stop bit 0, then line high -> `rx_data`=0x3C, `frame_err`=1, `break_det`=0. Next frame 0x55 -> flags clear.
- Line low for 3 frame times -> exactly one `rx_valid` with `rx_data`=0, `frame_err`=1, `break_det`=1. FSM stays in BRK until the line goes high. A subsequent 0x55 frame is received cleanly.
- `DATA_W`=5, `STOP_BITS`=2: send 0x15 -> `rx_data`=0x15, valid after the second stop decision. Assert `rst_n`=0 during data bit 3 of another frame -> all outputs 0 at once, no `rx_valid`. After release, 0x0A is received correctly.
